// File: rtl/uart_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uart_host_bridge
//  Purpose  : Glue between a host byte stream and a UART transmitter/receiver
//             pair. TX side hands one byte at a time to the transmitter and
//             waits out the frame using the baud ticker. RX side acknowledges
//             receiver interrupts and buffers bytes plus error flags in a
//             first-word-fall-through FIFO with a sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module uart_host_bridge #(
   parameter int RX_DEPTH       = 4,
   parameter int TX_FRAME_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ticker,
   // receiver side
   input  logic       host_interrupt,
   input  logic [7:0] outputDataBus,
   input  logic [2:0] err,
   output logic       host_aknowledged,
   // transmitter side
   output logic       send,
   output logic [7:0] inputDataBus,
   // host TX stream
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   // host RX stream
   output logic [7:0] rx_data,
   output logic [2:0] rx_err,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   input  logic       overrun_clr
);

   localparam int C_ADDR_W = $clog2(RX_DEPTH);
   localparam int C_CNT_W  = $clog2(TX_FRAME_TICKS + 1);
   localparam logic [C_CNT_W-1:0] C_FRAME_LAST = C_CNT_W'(TX_FRAME_TICKS - 1);

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_ARM   = 2'd1,
      T_FRAME = 2'd2
   } tx_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_ACK  = 1'b1
   } rx_state_t;

   // ------------------------------------------------------------------
   // Tick edge detection
   // ------------------------------------------------------------------
   logic ticker_q;
   logic tick;

   assign tick = ticker & ~ticker_q;

   // Ticker history for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset) ticker_q <= 1'b0;
      else        ticker_q <= ticker;
   end

   // ------------------------------------------------------------------
   // TX path
   // ------------------------------------------------------------------
   tx_state_t          tx_state_q, tx_state_d;
   logic               send_q, send_d;
   logic [7:0]         txbyte_q, txbyte_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;

   // TX state, transmitter handshake and frame tick counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state_q <= T_IDLE;
         send_q     <= 1'b0;
         txbyte_q   <= 8'h00;
         cnt_q      <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         send_q     <= send_d;
         txbyte_q   <= txbyte_d;
         cnt_q      <= cnt_d;
      end
   end

   // TX next state: latch byte, hold send until the first tick, then wait out the frame.
   always_comb begin
      tx_state_d = tx_state_q;
      send_d     = send_q;
      txbyte_d   = txbyte_q;
      cnt_d      = cnt_q;
      case (tx_state_q)
         T_IDLE: begin
            if (tx_valid) begin
               txbyte_d   = tx_data;
               send_d     = 1'b1;
               tx_state_d = T_ARM;
            end
         end
         T_ARM: begin
            if (tick) begin
               send_d     = 1'b0;
               cnt_d      = '0;
               tx_state_d = T_FRAME;
            end
         end
         T_FRAME: begin
            if (tick) begin
               if (cnt_q == C_FRAME_LAST) begin
                  cnt_d      = '0;
                  tx_state_d = T_IDLE;
               end else begin
                  cnt_d = cnt_q + C_CNT_W'(1);
               end
            end
         end
         default: begin
            send_d     = 1'b0;
            tx_state_d = T_IDLE;
         end
      endcase
   end

   assign tx_ready     = (tx_state_q == T_IDLE);
   assign send         = send_q;
   assign inputDataBus = txbyte_q;

   // ------------------------------------------------------------------
   // RX handshake
   // ------------------------------------------------------------------
   rx_state_t rx_state_q, rx_state_d;
   logic      ack_q, ack_d;
   logic      push;

   // RX handshake state and acknowledge registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_state_q <= R_IDLE;
         ack_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         ack_q      <= ack_d;
      end
   end

   // RX next state: one push per interrupt, acknowledge held until the interrupt falls.
   always_comb begin
      rx_state_d = rx_state_q;
      ack_d      = ack_q;
      push       = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (host_interrupt) begin
               push       = 1'b1;
               ack_d      = 1'b1;
               rx_state_d = R_ACK;
            end
         end
         R_ACK: begin
            if (!host_interrupt) begin
               ack_d      = 1'b0;
               rx_state_d = R_IDLE;
            end
         end
         default: begin
            ack_d      = 1'b0;
            rx_state_d = R_IDLE;
         end
      endcase
   end

   assign host_aknowledged = ack_q;

   // ------------------------------------------------------------------
   // RX FIFO: pointers carry one extra bit so full and empty differ
   // ------------------------------------------------------------------
   logic [10:0]         mem_q [RX_DEPTH];
   logic [C_ADDR_W:0]   wr_q, wr_d, rd_q, rd_d;
   logic                ovr_q, ovr_d;
   logic                empty, full, pop, wr_en, drop;
   logic [10:0]         head;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[C_ADDR_W] != rd_q[C_ADDR_W]) &&
                  (wr_q[C_ADDR_W-1:0] == rd_q[C_ADDR_W-1:0]);
   assign pop   = rx_ready & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   // FIFO pointer and overrun next state; a new drop beats a clear.
   always_comb begin
      wr_d  = wr_q + {{C_ADDR_W{1'b0}}, wr_en};
      rd_d  = rd_q + {{C_ADDR_W{1'b0}}, pop};
      ovr_d = ovr_q;
      if (drop)             ovr_d = 1'b1;
      else if (overrun_clr) ovr_d = 1'b0;
   end

   // FIFO pointers and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ovr_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ovr_q <= ovr_d;
      end
   end

   // FIFO storage: {err, data} written at the tail slot.
   always_ff @(posedge clk) begin
      if (reset && wr_en) mem_q[wr_q[C_ADDR_W-1:0]] <= {err, outputDataBus};
   end

   assign head       = mem_q[rd_q[C_ADDR_W-1:0]];
   assign rx_valid   = ~empty;
   assign rx_data    = empty ? 8'h00 : head[7:0];
   assign rx_err     = empty ? 3'b000 : head[10:8];
   assign rx_overrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_host_bridge
//  Purpose  : Self-checking bench for uart_host_bridge; scoreboard queues hold
//             expected TX bytes and RX FIFO entries, monitors compare them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_host_bridge;

   localparam int DEPTH = 4;
   localparam int FT    = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ticker;
   logic       host_interrupt = 1'b0;
   logic [7:0] outputDataBus = 8'h00;
   logic [2:0] err = 3'b000;
   logic       host_aknowledged;
   logic       send;
   logic [7:0] inputDataBus;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic [2:0] rx_err;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       rx_overrun;
   logic       overrun_clr = 1'b0;

   uart_host_bridge #(.RX_DEPTH(DEPTH), .TX_FRAME_TICKS(FT)) dut (
      .clk(clk), .reset(reset), .ticker(ticker),
      .host_interrupt(host_interrupt), .outputDataBus(outputDataBus), .err(err),
      .host_aknowledged(host_aknowledged), .send(send), .inputDataBus(inputDataBus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   // ticker: one-clk pulse every 16 clks while enabled
   logic       tick_en = 1'b0;
   logic [3:0] tcnt = 4'd0;
   always @(posedge clk) tcnt <= tcnt + 4'd1;
   assign ticker = tick_en && (tcnt == 4'd15);

   int tests = 0;
   int fails = 0;
   int occ   = 0;
   logic [10:0] rx_exp [$];
   logic [7:0]  tx_exp [$];
   logic [10:0] mon_e;
   logic [7:0]  mon_t;
   logic        send_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare FIFO head on every pop and transmitter byte on every send rise
   always @(negedge clk) begin
      if (reset) begin
         if (rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL rx_unexpected_pop: got %0h expected none", {rx_err, rx_data});
            end else begin
               mon_e = rx_exp.pop_front();
               check("rx_head", 32'({rx_err, rx_data}), 32'(mon_e));
            end
         end
         if (send && !send_prev) begin
            if (tx_exp.size() == 0) begin
               tests++; fails++;
               $display("FAIL tx_unexpected_send: got %0h expected none", inputDataBus);
            end else begin
               mon_t = tx_exp.pop_front();
               check("tx_byte", 32'(inputDataBus), 32'(mon_t));
            end
         end
      end
      send_prev <= send;
   end

   // send one byte and track send/tx_ready against the ticks the bench generated
   task automatic tx_send(input logic [7:0] d);
      int  ticks;
      bit  done;
      tx_exp.push_back(d);
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = d;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      ticks = 0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         check("tx_send", 32'(send), 32'(ticks == 0));
         check("tx_ready", 32'(tx_ready), 32'(ticks >= FT + 1));
         check("tx_bus", 32'(inputDataBus), 32'(d));
         if (ticks >= FT + 1) done = 1'b1;
         else begin
            @(posedge clk);
            if (ticker) ticks++;
            #1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL tx_timeout: got %0d ticks expected %0d", ticks, FT + 1);
      end
   endtask

   // one receiver interrupt held for 'hold' clks
   task automatic rx_irq(input logic [7:0] d, input logic [2:0] e, input int hold,
                         input bit pop_same, input bit clr_same);
      @(posedge clk); #1;
      host_interrupt = 1'b1; outputDataBus = d; err = e;
      if (pop_same) rx_ready = 1'b1;
      if (clr_same) overrun_clr = 1'b1;
      if (occ < DEPTH || pop_same) begin
         rx_exp.push_back({e, d});
         if (!pop_same) occ++;
      end
      @(negedge clk);
      check("ack_before_rise", 32'(host_aknowledged), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin rx_ready = 1'b0; overrun_clr = 1'b0; end
         if (i == hold - 1) host_interrupt = 1'b0;
         @(negedge clk);
         check("ack_held", 32'(host_aknowledged), 32'd1);
      end
      @(negedge clk);
      check("ack_dropped", 32'(host_aknowledged), 32'd0);
   endtask

   // pop everything; return number of entries popped
   task automatic drain(output int n);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!rx_valid) break;
         n++;
      end
      @(posedge clk); #1;
      rx_ready = 1'b0;
      occ = 0;
   endtask

   initial begin
      int n;
      int tk;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_send", 32'(send), 32'd0);
      check("rst_ack", 32'(host_aknowledged), 32'd0);
      check("rst_bus", 32'(inputDataBus), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_err", 32'(rx_err), 32'd0);
      check("rst_overrun", 32'(rx_overrun), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; tick_en = 1'b1;

      // TX frames
      tx_send(8'hA5);
      tx_send(8'h5A);

      // single interrupt, 5 clks
      rx_irq(8'h3C, 3'b010, 5, 1'b0, 1'b0);
      @(negedge clk);
      check("rx1_valid", 32'(rx_valid), 32'd1);
      check("rx1_data", 32'(rx_data), 32'h3C);
      check("rx1_err", 32'(rx_err), 32'h2);
      drain(n);
      check("rx1_count", 32'(n), 32'd1);

      // five interrupts into a depth-4 FIFO
      rx_irq(8'h11, 3'd1, 2, 1'b0, 1'b0);
      rx_irq(8'h22, 3'd2, 2, 1'b0, 1'b0);
      rx_irq(8'h33, 3'd3, 2, 1'b0, 1'b0);
      rx_irq(8'h44, 3'd4, 2, 1'b0, 1'b0);
      @(negedge clk);
      check("full_no_overrun", 32'(rx_overrun), 32'd0);
      rx_irq(8'h55, 3'd5, 2, 1'b0, 1'b0);
      @(negedge clk);
      check("overrun_set", 32'(rx_overrun), 32'd1);
      check("ovf_head", 32'(rx_data), 32'h11);
      drain(n);
      check("ovf_count", 32'(n), 32'd4);
      @(negedge clk);
      check("overrun_sticky", 32'(rx_overrun), 32'd1);
      @(posedge clk); #1; overrun_clr = 1'b1;
      @(posedge clk); #1; overrun_clr = 1'b0;
      @(negedge clk);
      check("overrun_cleared", 32'(rx_overrun), 32'd0);

      // overrun coinciding with a clear: overrun wins
      rx_irq(8'h61, 3'd0, 1, 1'b0, 1'b0);
      rx_irq(8'h62, 3'd1, 1, 1'b0, 1'b0);
      rx_irq(8'h63, 3'd2, 1, 1'b0, 1'b0);
      rx_irq(8'h64, 3'd3, 1, 1'b0, 1'b0);
      rx_irq(8'h99, 3'd7, 1, 1'b0, 1'b1);
      @(negedge clk);
      check("ovr_beats_clr", 32'(rx_overrun), 32'd1);
      drain(n);
      check("ovr_clr_count", 32'(n), 32'd4);
      @(posedge clk); #1; overrun_clr = 1'b1;
      @(posedge clk); #1; overrun_clr = 1'b0;

      // full FIFO, push coinciding with pop
      rx_irq(8'hA1, 3'd1, 1, 1'b0, 1'b0);
      rx_irq(8'hA2, 3'd2, 1, 1'b0, 1'b0);
      rx_irq(8'hA3, 3'd3, 1, 1'b0, 1'b0);
      rx_irq(8'hA4, 3'd4, 1, 1'b0, 1'b0);
      rx_irq(8'hB5, 3'd5, 2, 1'b1, 1'b0);
      @(negedge clk);
      check("pushpop_no_overrun", 32'(rx_overrun), 32'd0);
      check("pushpop_head", 32'(rx_data), 32'hA2);
      drain(n);
      check("pushpop_count", 32'(n), 32'd4);

      // reset during T_FRAME and R_ACK
      tx_exp.push_back(8'hC3);
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = 8'hC3;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tk = 0;
      for (int i = 0; i < 200 && tk < 3; i++) begin
         @(posedge clk);
         if (ticker) tk++;
         #1;
      end
      check("rst_pre_frame", 32'(tx_ready), 32'd0);
      host_interrupt = 1'b1; outputDataBus = 8'h7E; err = 3'b111;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_pre_ack", 32'(host_aknowledged), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_send", 32'(send), 32'd0);
      check("midrst_ack", 32'(host_aknowledged), 32'd0);
      check("midrst_tx_ready", 32'(tx_ready), 32'd1);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      check("midrst_bus", 32'(inputDataBus), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      rx_exp.push_back({3'b111, 8'h7E});
      @(posedge clk); #1;
      @(negedge clk);
      check("rel_ack", 32'(host_aknowledged), 32'd1);
      check("rel_rx_valid", 32'(rx_valid), 32'd1);
      check("rel_rx_data", 32'(rx_data), 32'h7E);
      check("rel_no_send", 32'(send), 32'd0);
      @(posedge clk); #1;
      host_interrupt = 1'b0;
      drain(n);
      check("rel_count", 32'(n), 32'd1);
      check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/uart_host_bridge.md
UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 Parameter: RX_DEPTH, default 4, receive FIFO depth in entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter: TX_FRAME_TICKS, default 10, ticker rising edges per transmitted frame.
REQ-003 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 ticker  in  1  transmit bit-rate tick from the baud generator, synchronous to clk.
REQ-006 host_interrupt  in  1  receiver flags a byte ready on outputDataBus.
REQ-007 outputDataBus  in  8  received byte from the receiver.
REQ-008 err  in  3  receiver error flags for that byte.
REQ-009 host_aknowledged  out  1  acknowledge to the receiver.
REQ-010 send  out  1  transmitter enable.
REQ-011 inputDataBus  out  8  byte presented to the transmitter.
REQ-012 tx_data  in  8  host byte to transmit.
REQ-013 tx_valid  in  1  host byte offered.
REQ-014 tx_ready  out  1  bridge accepts a byte.
REQ-015 rx_data  out  8  FIFO head byte.
REQ-016 rx_err  out  3  FIFO head error flags.
REQ-017 rx_valid  out  1  FIFO not empty.
REQ-018 rx_ready  in  1  host pops the head.
REQ-019 rx_overrun  out  1  sticky flag: a byte was dropped.
REQ-020 overrun_clr  in  1  clears rx_overrun.

Function
REQ-021 A tick event SHALL be ticker=1 with the previous-cycle registered ticker=0, giving a one-clk pulse per ticker rising edge.
REQ-022 The TX FSM SHALL have three states: T_IDLE, T_ARM, and T_FRAME.
REQ-023 tx_ready SHALL be 1 only in T_IDLE.
REQ-024 T_IDLE with tx_valid=1: latch tx_data into inputDataBus, set send=1, and go to T_ARM on the next edge.
REQ-025 T_ARM SHALL hold send=1 and inputDataBus stable until the first tick event, then set send=0 and go to T_FRAME.
REQ-026 T_FRAME SHALL count tick events and return to T_IDLE when the count reaches TX_FRAME_TICKS.
REQ-027 The count SHALL have width ceil(log2(TX_FRAME_TICKS+1)) and SHALL be cleared on entry to T_FRAME.
REQ-028 inputDataBus SHALL hold its last value outside T_ARM.
REQ-029 The RX FSM SHALL have two states: R_IDLE and R_ACK.
REQ-030 R_IDLE with host_interrupt=1: push {err, outputDataBus} into the FIFO, set host_aknowledged=1 on the next edge, and go to R_ACK.
REQ-031 R_ACK SHALL hold host_aknowledged=1 while host_interrupt=1; on the first cycle with host_interrupt=0 it SHALL drop host_aknowledged and return to R_IDLE; each interrupt SHALL produce exactly one push.
REQ-032 A push while full with no pop SHALL discard the byte, set rx_overrun=1, and still acknowledge.
REQ-033 A push and pop in the same cycle when full SHALL both take effect; no overrun SHALL be flagged and the count SHALL be unchanged.
REQ-034 A push and pop in the same cycle when empty SHALL be impossible, since rx_valid=0; rx_ready with rx_valid=0 SHALL be ignored.
REQ-035 The FIFO SHALL be first-word-fall-through: rx_data and rx_err reflect the head while rx_valid=1, and a pushed byte SHALL appear one cycle after the push edge.
REQ-036 Read and write pointers SHALL wrap modulo RX_DEPTH; an extra occupancy bit SHALL distinguish full from empty.
REQ-037 If overrun_clr=1 and a new overrun occur in the same cycle, the overrun SHALL win and rx_overrun stays 1.
REQ-038 The TX and RX paths SHALL be fully independent and operate concurrently.

Reset
REQ-039 While reset=0 at a clk edge: both FSMs go idle; send=0, host_aknowledged=0, inputDataBus=0, rx_overrun=0, FIFO emptied (rx_valid=0, rx_data=0, rx_err=0), tick counter and ticker history=0.
REQ-040 Reset mid-frame or mid-handshake SHALL abort with no residual push or send; an interrupt still high after reset release SHALL be treated as new.

Verification
REQ-041 tx_valid=1, tx_data=8'hA5, tick every 16 clks -> send=1 and inputDataBus=A5 until the first tick event, then send=0; tx_ready returns 1 after exactly 10 further tick events.
REQ-042 host_interrupt held high for 5 clks with data=8'h3C, err=3'b010 -> host_aknowledged high one clk after the rise and until the interrupt falls; exactly one FIFO entry; rx_data=3C, rx_err=010.
REQ-043 Five interrupts with rx_ready=0, RX_DEPTH=4 -> four entries kept in order, fifth dropped, rx_overrun=1; overrun_clr pulse clears it.
REQ-044 FIFO full, and an interrupt push coincides with rx_ready=1 -> head popped, new byte stored at the tail, rx_overrun stays 0, occupancy stays 4.
REQ-045 reset=0 asserted while in T_FRAME and R_ACK -> next cycle send=0, host_aknowledged=0, tx_ready=1, rx_valid=0.
